// File: rtl/redux_cpa_pkg.sv
// rtl/redux_cpa_pkg.sv - shared alu package: state encoding for the slice-serial carry-propagate adder
package redux_cpa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } cpa_state_e;

endpackage

// File: rtl/redux_cpa_slice.sv
// rtl/redux_cpa_slice.sv - combinational D-bit adder slice with carry in and carry out
module redux_cpa_slice #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, cin};

endmodule

// File: rtl/redux_cpa.sv
// rtl/redux_cpa.sv - resolves a carry-save pair into a binary sum, D bits per cycle, LSB slice first
module redux_cpa
  import redux_cpa_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x [2],
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] q,
  output logic         c,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N  = W / D;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if ((D < 1) || (D > W) || ((W % D) != 0)) begin : g_param_check
    $error("redux_cpa: W must be a multiple of D with 1 <= D <= W");
  end

  cpa_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  q_q, q_d;
  logic          c_q, c_d;

  logic [D-1:0]  op_a, op_b, slice_sum;
  logic          slice_cout;
  logic          accept;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign c         = c_q;

  // Operand slice k feeds the single shared adder slice.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        op_a = a_q[i*D +: D];
        op_b = b_q[i*D +: D];
      end
    end
  end

  redux_cpa_slice #(
    .D(D)
  ) u_slice (
    .a   (op_a),
    .b   (op_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    c_d     = c_q;
    case (state_q)
      BUSY: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) q_d[i*D +: D] = slice_sum;
        end
        carry_d = slice_cout;
        if (k_q == KW'(N - 1)) begin
          state_d = DONE;
          c_d     = slice_cout;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accepting in DONE overrides the return to IDLE, giving back-to-back operation.
    if (accept) begin
      state_d = BUSY;
      a_d     = x[0];
      b_d     = x[1];
      k_d     = '0;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_redux_cpa.sv
// tb/tb_redux_cpa.sv - directed self-checking bench for redux_cpa (W=8/D=4 and W=8/D=8)
module tb_redux_cpa;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] xa [2];
  logic       iva, ira, ova, ora;
  logic [7:0] qa;
  logic       ca;

  logic [7:0] xb [2];
  logic       ivb, irb, ovb, orb;
  logic [7:0] qb;
  logic       cb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  redux_cpa #(.W(8), .D(4)) u_dut_a (
    .clk(clk), .reset(reset), .x(xa), .in_valid(iva), .in_ready(ira),
    .q(qa), .c(ca), .out_valid(ova), .out_ready(ora)
  );

  redux_cpa #(.W(8), .D(8)) u_dut_b (
    .clk(clk), .reset(reset), .x(xb), .in_valid(ivb), .in_ready(irb),
    .q(qb), .c(cb), .out_valid(ovb), .out_ready(orb)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ova !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_a got %b want 0", ova); end
    n_cmp++; if (qa !== 8'h00) begin n_bad++; $display("FAIL reset_q_a got %h want 00", qa); end
    n_cmp++; if (ca !== 1'b0) begin n_bad++; $display("FAIL reset_c_a got %b want 0", ca); end
    n_cmp++; if (ira !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_a got %b want 1", ira); end
    n_cmp++; if (ovb !== 1'b0 || irb !== 1'b1) begin n_bad++; $display("FAIL reset_b got ov=%b ir=%b want ov=0 ir=1", ovb, irb); end
  endtask

  // Accept one pair on DUT A, expect the result N+1 = 3 cycles later, then hand it off.
  task automatic test_add(input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] exp_q, input logic exp_c, input string name);
    int n;
    @(posedge clk);
    #1 xa[0] = x0; xa[1] = x1; iva = 1'b1; ora = 1'b1;
    @(negedge clk);
    n_cmp++; if (ira !== 1'b1) begin n_bad++; $display("FAIL %s_idle_ready got %b want 1", name, ira); end
    @(posedge clk);
    #1 iva = 1'b0; xa[0] = ~x0; xa[1] = 8'h5A;
    n = 0;
    do begin @(negedge clk); n++; end while (ova !== 1'b1 && n < 10);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL %s_latency got %0d want 3", name, n); end
    n_cmp++; if (qa !== exp_q) begin n_bad++; $display("FAIL %s_q got %h want %h", name, qa, exp_q); end
    n_cmp++; if (ca !== exp_c) begin n_bad++; $display("FAIL %s_c got %b want %b", name, ca, exp_c); end
    @(negedge clk);
    n_cmp++; if (ova !== 1'b0 || qa !== exp_q || ca !== exp_c) begin
      n_bad++; $display("FAIL %s_idle_hold got ov=%b q=%h c=%b want ov=0 q=%h c=%b", name, ova, qa, ca, exp_q, exp_c);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(posedge clk);
    #1 xa[0] = 8'h33; xa[1] = 8'h44; iva = 1'b1; ora = 1'b0;
    @(posedge clk);
    #1 xa[0] = 8'h01; xa[1] = 8'h01;
    n = 0;
    do begin @(negedge clk); n++; end while (ova !== 1'b1 && n < 10);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL bp_latency got %0d want 3", n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ova !== 1'b1 || qa !== 8'h77 || ca !== 1'b0 || ira !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold_%0d got ov=%b q=%h c=%b ir=%b want ov=1 q=77 c=0 ir=0", i, ova, qa, ca, ira);
      end
      @(negedge clk);
    end
    #1 ora = 1'b1; iva = 1'b0;
    #1;
    n_cmp++; if (ira !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", ira); end
    @(negedge clk);
    n_cmp++; if (ova !== 1'b0 || ira !== 1'b1) begin n_bad++; $display("FAIL bp_idle got ov=%b ir=%b want ov=0 ir=1", ova, ira); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk);
    #1 xa[0] = 8'h12; xa[1] = 8'h34; iva = 1'b1; ora = 1'b1;
    @(posedge clk);
    #1 xa[0] = 8'h80; xa[1] = 8'h80;
    n = 0;
    do begin @(negedge clk); n++; end while (ova !== 1'b1 && n < 10);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 3", n); end
    n_cmp++; if (qa !== 8'h46 || ca !== 1'b0) begin n_bad++; $display("FAIL b2b_first got q=%h c=%b want q=46 c=0", qa, ca); end
    n_cmp++; if (ira !== 1'b1) begin n_bad++; $display("FAIL b2b_done_ready got %b want 1", ira); end
    @(posedge clk);
    #1 iva = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ova !== 1'b1 && n < 10);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL b2b_spacing got %0d want 3", n); end
    n_cmp++; if (qa !== 8'h00 || ca !== 1'b1) begin n_bad++; $display("FAIL b2b_second got q=%h c=%b want q=00 c=1", qa, ca); end
    @(negedge clk);
    n_cmp++; if (ova !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", ova); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk);
    #1 xa[0] = 8'h0F; xa[1] = 8'h01; iva = 1'b1; ora = 1'b1;
    @(posedge clk);
    #1 iva = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ova !== 1'b0 || qa !== 8'h00 || ca !== 1'b0 || ira !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid got ov=%b q=%h c=%b ir=%b want ov=0 q=00 c=0 ir=1", ova, qa, ca, ira);
    end
    seen = 0;
    repeat (5) begin @(negedge clk); if (ova === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_stale got %0d results want 0", seen); end
  endtask

  task automatic test_n1();
    int n;
    @(posedge clk);
    #1 xb[0] = 8'hF0; xb[1] = 8'h20; ivb = 1'b1; orb = 1'b1;
    @(posedge clk);
    #1 ivb = 1'b0; xb[0] = 8'h00;
    n = 0;
    do begin @(negedge clk); n++; end while (ovb !== 1'b1 && n < 10);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL n1_latency got %0d want 2", n); end
    n_cmp++; if (qb !== 8'h10 || cb !== 1'b1) begin n_bad++; $display("FAIL n1_result got q=%h c=%b want q=10 c=1", qb, cb); end
  endtask

  initial begin
    xa[0] = 8'h00; xa[1] = 8'h00; iva = 1'b0; ora = 1'b0;
    xb[0] = 8'h00; xb[1] = 8'h00; ivb = 1'b0; orb = 1'b0;
    test_reset();
    test_add(8'h0F, 8'h01, 8'h10, 1'b0, "add_0f_01");
    test_add(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
    test_add(8'hA5, 8'h5A, 8'hFF, 1'b0, "add_a5_5a");
    test_add(8'h9C, 8'h87, 8'h23, 1'b1, "add_9c_87");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/redux_cpa.md
REDUX_CPA -- requirements
Module: redux_cpa

Interface
REQ-001 SHALL have parameter W, default 8: operand and result width in bits.
REQ-002 SHALL have parameter D, default 4: slice width added per cycle; W % D == 0 and 1 <= D <= W, else elaboration error.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port x  input  [W-1:0] x[2]: carry-save pair from the M:2 reductor.
REQ-006 SHALL have port in_valid  input  1: x is valid.
REQ-007 SHALL have port in_ready  output  1: block can accept x.
REQ-008 SHALL have port q  output  W: resolved sum, x[0] + x[1] mod 2^W.
REQ-009 SHALL have port c  output  1: carry out of bit W-1.
REQ-010 SHALL have port out_valid  output  1: q and c are valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts q and c.

Function
REQ-012 SHALL use states IDLE, BUSY and DONE, with N = W/D slice steps.
REQ-013 SHALL drive in_ready = (state == IDLE) | (state == DONE & out_ready); the combinational out_ready-to-in_ready path is intended.
REQ-014 SHALL accept on in_valid & in_ready in cycle T: latch x[0] and x[1], clear slice index k and carry, and go to BUSY.
REQ-015 SHALL sample x only at acceptance; later changes on x have no effect.
REQ-016 SHALL, in BUSY at cycle T+1+k, add slice k (bits k*D+D-1 .. k*D) of both operands plus the carry register, write the D-bit sum into q slice k, and register the slice carry.
REQ-017 SHALL process slices LSB first, k = 0 .. N-1, then go to DONE after slice N-1.
REQ-018 SHALL set c to the carry out of slice N-1.
REQ-019 SHALL assert out_valid only in DONE, first at cycle T+N+1 (latency N+1 cycles from acceptance).
REQ-020 SHALL hold q, c and out_valid stable while out_valid & !out_ready.
REQ-021 SHALL, on out_valid & out_ready, go to IDLE, or to BUSY if a new input is accepted in the same cycle.
REQ-022 SHALL, on back-to-back operation, sustain one result per N+1 cycles and keep results in order.
REQ-023 SHALL ignore in_valid in BUSY, with in_ready low.
REQ-024 SHALL keep q and c from the last result while in IDLE.

Reset
REQ-025 SHALL, with reset high at an edge, go to IDLE and clear q, c, the carry register, k and out_valid, regardless of state or handshakes in that cycle.
REQ-026 SHALL discard an operation interrupted by reset, emit no result for it, and have in_ready = 1 in the cycle after reset deasserts.

Structure
REQ-027 SHALL keep the state enum (IDLE, BUSY, DONE) in the shared alu package; N and the slice-index width ($clog2(N), minimum 1) SHALL be local parameters.
REQ-028 SHALL instantiate one sub-module, redux_cpa_slice: a combinational D-bit adder with carry in and carry out.

Verification
REQ-029 SHALL cover (W=8, D=4): x = {0x0F, 0x01} accepted at T -> out_valid at T+3, q = 0x10, c = 0.
REQ-030 SHALL cover (W=8, D=4): x = {0xFF, 0x01} -> q = 0x00, c = 1, with the carry passed from slice 0 into slice 1.
REQ-031 SHALL cover backpressure: out_ready low for 5 cycles after out_valid -> q and c constant, in_ready = 0, no new accept; out_ready = 1 -> handshake, then IDLE.
REQ-032 SHALL cover back-to-back: in_valid and out_ready held high with {0x12, 0x34} then {0x80, 0x80} -> second input accepted in the DONE cycle of the first; outputs 0x46 / c=0, then 0x00 / c=1, 3 cycles apart.
REQ-033 SHALL cover reset mid-operation: reset at BUSY k=0 -> next cycle out_valid = 0, q = 0, c = 0, in_ready = 1; no stale result appears.
REQ-034 SHALL cover the boundary W=8, D=8 (N=1): {0xF0, 0x20} -> out_valid 2 cycles after accept, q = 0x10, c = 1.
